// File: rtl/sweep_channel_tracker_if.sv
// Bundles the slope-flag inputs, dwell control and channel/sweep outputs of
// sweep_channel_tracker; master drives the flags, slave is the tracker.
interface sweep_channel_tracker_if #(
    parameter int unsigned CHAN_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                  rising;
    logic                  falling;
    logic [CNT_WIDTH-1:0]  dwell_cycles;
    logic [CHAN_WIDTH-1:0] channel;
    logic                  channel_valid;
    logic                  direction;
    logic                  turn_pulse;
    logic [CNT_WIDTH-1:0]  half_period;
    logic [CNT_WIDTH-1:0]  sweep_count;
    logic                  overrun;

    modport master (
        output rising, falling, dwell_cycles,
        input  channel, channel_valid, direction, turn_pulse, half_period, sweep_count, overrun
    );

    modport slave (
        input  rising, falling, dwell_cycles,
        output channel, channel_valid, direction, turn_pulse, half_period, sweep_count, overrun
    );
endinterface

// File: rtl/sweep_channel_tracker.sv
// Debounced UP/DOWN half-sweep tracker with dwell-rate channel stepping and period measurement.
// Define SWEEP_MIRROR_EN to map DOWN half-sweeps onto channels NUM_CHAN..2*NUM_CHAN-1.
module sweep_channel_tracker #(
    parameter int unsigned NUM_CHAN   = 512,
    parameter int unsigned CHAN_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned DEBOUNCE   = 4
) (
    input logic                   slow_clk,
    input logic                   rst,
    sweep_channel_tracker_if.slave bus
);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e                r_state, w_state_d;
    logic [DEB_W-1:0]      r_deb_cnt, w_deb_cnt_d;
    logic [CHAN_WIDTH-1:0] r_chan_idx, w_chan_idx_d;
    logic [CNT_WIDTH-1:0]  r_dwell_cnt, w_dwell_cnt_d;
    logic [CNT_WIDTH-1:0]  r_half_cnt, w_half_cnt_d;
    logic [CNT_WIDTH-1:0]  r_half_period, w_half_period_d;
    logic [CNT_WIDTH-1:0]  r_sweep_count, w_sweep_count_d;
    logic                  r_overrun, w_overrun_d;
    logic                  r_direction, w_direction_d;
    logic                  r_turn_pulse, w_turn_pulse_d;
    logic [CHAN_WIDTH-1:0] r_channel, w_channel_d;
    logic                  r_channel_valid, w_channel_valid_d;

    logic                  w_up_q, w_dn_q, w_target, w_confirm;
    logic [CNT_WIDTH-1:0]  w_dwell_lim;

    always_comb begin
        w_up_q      = bus.rising & ~bus.falling;
        w_dn_q      = bus.falling & ~bus.rising;
        w_target    = (r_state == StUp) ? w_dn_q : w_up_q;
        w_confirm   = w_target && (r_deb_cnt == DEB_W'(DEBOUNCE - 1));
        w_dwell_lim = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - 1'b1;

        w_state_d       = r_state;
        w_deb_cnt_d     = (w_target && !w_confirm) ? r_deb_cnt + 1'b1 : '0;
        w_chan_idx_d    = r_chan_idx;
        w_dwell_cnt_d   = r_dwell_cnt;
        w_half_cnt_d    = r_half_cnt;
        w_half_period_d = r_half_period;
        w_sweep_count_d = r_sweep_count;
        w_overrun_d     = r_overrun;
        w_direction_d   = r_direction;
        w_turn_pulse_d  = 1'b0;

        if (w_confirm) begin
            // A turnaround overrides any dwell wrap landing on the same edge.
            w_chan_idx_d  = '0;
            w_dwell_cnt_d = '0;
            w_overrun_d   = 1'b0;
            w_half_cnt_d  = '0;
            case (r_state)
                StIdle: begin
                    w_state_d     = StUp;
                    w_direction_d = 1'b1;
                end
                StUp: begin
                    w_state_d       = StDown;
                    w_direction_d   = 1'b0;
                    w_turn_pulse_d  = 1'b1;
                    w_half_period_d = r_half_cnt + 1'b1;
                end
                StDown: begin
                    w_state_d       = StUp;
                    w_direction_d   = 1'b1;
                    w_turn_pulse_d  = 1'b1;
                    w_half_period_d = r_half_cnt + 1'b1;
                    w_sweep_count_d = r_sweep_count + 1'b1;
                end
                default: w_state_d = StIdle;
            endcase
        end else if (r_state != StIdle) begin
            if (r_half_cnt != '1) w_half_cnt_d = r_half_cnt + 1'b1;
            // >= so a shrinking dwell_cycles cannot skip past the wrap point.
            if (r_dwell_cnt >= w_dwell_lim) begin
                w_dwell_cnt_d = '0;
                if (r_chan_idx == CHAN_WIDTH'(NUM_CHAN - 1)) w_overrun_d = 1'b1;
                else w_chan_idx_d = r_chan_idx + 1'b1;
            end else begin
                w_dwell_cnt_d = r_dwell_cnt + 1'b1;
            end
        end

`ifdef SWEEP_MIRROR_EN
        if (w_state_d == StDown) w_channel_d = CHAN_WIDTH'(2 * NUM_CHAN - 1) - w_chan_idx_d;
        else w_channel_d = w_chan_idx_d;
`else
        w_channel_d = w_chan_idx_d;
`endif
        w_channel_valid_d = (w_state_d != StIdle) & ~w_overrun_d;
    end

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_deb_cnt       <= '0;
            r_chan_idx      <= '0;
            r_dwell_cnt     <= '0;
            r_half_cnt      <= '0;
            r_half_period   <= '0;
            r_sweep_count   <= '0;
            r_overrun       <= 1'b0;
            r_direction     <= 1'b0;
            r_turn_pulse    <= 1'b0;
            r_channel       <= '0;
            r_channel_valid <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_deb_cnt       <= w_deb_cnt_d;
            r_chan_idx      <= w_chan_idx_d;
            r_dwell_cnt     <= w_dwell_cnt_d;
            r_half_cnt      <= w_half_cnt_d;
            r_half_period   <= w_half_period_d;
            r_sweep_count   <= w_sweep_count_d;
            r_overrun       <= w_overrun_d;
            r_direction     <= w_direction_d;
            r_turn_pulse    <= w_turn_pulse_d;
            r_channel       <= w_channel_d;
            r_channel_valid <= w_channel_valid_d;
        end
    end

    assign bus.channel       = r_channel;
    assign bus.channel_valid = r_channel_valid;
    assign bus.direction     = r_direction;
    assign bus.turn_pulse    = r_turn_pulse;
    assign bus.half_period   = r_half_period;
    assign bus.sweep_count   = r_sweep_count;
    assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_sweep_channel_tracker.sv
// Directed bench for sweep_channel_tracker: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sweep_channel_tracker;
    localparam int unsigned NC = 8;
    localparam int unsigned CW = 5;
    localparam int unsigned VW = 73;

    localparam logic [VW-1:0] M_CH  = {5'h1f, 4'b0000, 64'b0};
    localparam logic [VW-1:0] M_V   = {5'h00, 4'b1000, 64'b0};
    localparam logic [VW-1:0] M_D   = {5'h00, 4'b0100, 64'b0};
    localparam logic [VW-1:0] M_T   = {5'h00, 4'b0010, 64'b0};
    localparam logic [VW-1:0] M_O   = {5'h00, 4'b0001, 64'b0};
    localparam logic [VW-1:0] M_ALL = {VW{1'b1}};

    typedef struct {
        string         tag;
        int            stamp;
        logic [VW-1:0] exp;
        logic [VW-1:0] mask;
    } chk_t;

    logic slow_clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    chk_t q[$];
    chk_t mc;
    logic [VW-1:0] act;

    sweep_channel_tracker_if #(.CHAN_WIDTH(CW), .CNT_WIDTH(32)) bus ();

    sweep_channel_tracker #(
        .NUM_CHAN  (NC),
        .CHAN_WIDTH(CW),
        .CNT_WIDTH (32),
        .DEBOUNCE  (4)
    ) dut (
        .slow_clk(slow_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 slow_clk = ~slow_clk;
    always @(posedge slow_clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] mk(input int ch, input bit v, input bit d, input bit t,
                                         input bit o, input int hp, input int sc);
        return {CW'(ch), v, d, t, o, 32'(hp), 32'(sc)};
    endfunction

    function automatic int dn(input int i);
`ifdef SWEEP_MIRROR_EN
        return 2 * NC - 1 - i;
`else
        return i;
`endif
    endfunction

    task automatic tick(input logic r, input logic f);
        bus.rising  = r;
        bus.falling = f;
        @(posedge slow_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] e, input logic [VW-1:0] m);
        chk_t c;
        c.tag   = tag;
        c.stamp = cyc;
        c.exp   = e;
        c.mask  = m;
        q.push_back(c);
    endtask

    always @(negedge slow_clk) begin
        while (q.size() > 0 && q[0].stamp == cyc) begin
            mc  = q.pop_front();
            act = {bus.channel, bus.channel_valid, bus.direction, bus.turn_pulse, bus.overrun,
                   bus.half_period, bus.sweep_count};
            n_cmp++;
            if ((act & mc.mask) !== (mc.exp & mc.mask)) begin
                n_bad++;
                $display("FAIL %s: got {ch,v,d,t,o,hp,sc}=%h required %h (mask %h)",
                         mc.tag, act, mc.exp, mc.mask);
            end
        end
    end

    initial begin
        bus.rising       = 1'b0;
        bus.falling      = 1'b0;
        bus.dwell_cycles = 32'd3;
        rst              = 1'b1;
        tick(0, 0);
        tick(0, 0);
        chk("reset", mk(0, 0, 0, 0, 0, 0, 0), M_ALL);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick(0, 0);
        chk("idle_quiet", mk(0, 0, 0, 0, 0, 0, 0), M_ALL);

        // Debounce: a 3-cycle burst must not confirm.
        for (int i = 0; i < 3; i++) tick(1, 0);
        chk("deb_short", mk(0, 0, 0, 0, 0, 0, 0), M_ALL);
        tick(0, 0);
        for (int i = 0; i < 3; i++) tick(1, 0);
        chk("deb_pre", mk(0, 0, 0, 0, 0, 0, 0), M_V | M_D);
        tick(1, 0);
        chk("enter_up", mk(0, 1, 1, 0, 0, 0, 0), M_ALL);

        for (int k = 1; k <= 29; k++) begin
            tick(1, 0);
            if (k == 1)  chk("up_k1", mk(0, 1, 1, 0, 0, 0, 0), M_ALL);
            if (k == 3)  chk("up_k3", mk(1, 1, 1, 0, 0, 0, 0), M_CH | M_V | M_O);
            if (k == 20) chk("up_k20", mk(6, 1, 1, 0, 0, 0, 0), M_CH | M_V | M_O);
            if (k == 21) chk("up_k21", mk(7, 1, 1, 0, 0, 0, 0), M_CH | M_V | M_O);
            if (k == 23) chk("up_k23", mk(7, 1, 1, 0, 0, 0, 0), M_CH | M_V | M_O);
            if (k == 24) chk("up_ovr", mk(7, 0, 1, 0, 1, 0, 0), M_ALL);
        end
        for (int i = 0; i < 3; i++) tick(0, 1);
        chk("up_pre_turn", mk(7, 0, 1, 0, 1, 0, 0), M_ALL);
        tick(0, 1);
        chk("turn_down", mk(dn(0), 1, 0, 1, 0, 33, 0), M_ALL);

        for (int j = 1; j <= 30; j++) begin
            tick(0, 1);
            if (j == 1)  chk("down_j1", mk(dn(0), 1, 0, 0, 0, 33, 0), M_ALL);
            if (j == 3)  chk("down_j3", mk(dn(1), 1, 0, 0, 0, 33, 0), M_ALL);
            if (j == 24) chk("down_ovr", mk(dn(7), 0, 0, 0, 1, 33, 0), M_ALL);
        end
        for (int i = 0; i < 3; i++) tick(1, 0);
        chk("down_pre_turn", mk(0, 0, 0, 0, 1, 33, 0), M_D | M_T | M_SC_HP());
        tick(1, 0);
        chk("turn_up", mk(0, 1, 1, 1, 0, 34, 1), M_ALL);

        // dwell_cycles = 0 steps every cycle.
        bus.dwell_cycles = 32'd0;
        tick(1, 0);
        chk("dwell0_1", mk(1, 1, 1, 0, 0, 34, 1), M_ALL);
        for (int i = 0; i < 4; i++) tick(1, 0);
        chk("dwell0_5", mk(5, 1, 1, 0, 0, 34, 1), M_ALL);

        // Both-high cycles clear a partial debounce count.
        for (int i = 0; i < 3; i++) tick(0, 1);
        for (int i = 0; i < 10; i++) tick(1, 1);
        chk("both_high", mk(7, 0, 1, 0, 1, 34, 1), M_ALL);
        for (int i = 0; i < 3; i++) tick(0, 1);
        chk("deb_cleared", mk(7, 0, 1, 0, 1, 34, 1), M_ALL);
        tick(0, 1);
        chk("turn_down2", mk(dn(0), 1, 0, 1, 0, 22, 1), M_ALL);
        tick(0, 1);
        chk("down2_step", mk(dn(1), 1, 0, 0, 0, 22, 1), M_ALL);

        rst = 1'b1;
        tick(0, 1);
        chk("rst_in_down", mk(0, 0, 0, 0, 0, 0, 0), M_ALL);
        rst = 1'b0;
        tick(0, 0);
        chk("after_rst", mk(0, 0, 0, 0, 0, 0, 0), M_ALL);

        @(negedge slow_clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [VW-1:0] M_SC_HP();
        return {41'b0, 32'hffff_ffff} | {9'b0, 32'hffff_ffff, 32'b0};
    endfunction
endmodule
